niosii_test_nios2_gen2_0_cpu_div_cell: RTL and testbench

//  Iterative 32/32 integer divider for the CPU execute stage; the inverse-operation companion of the mult cell.

---
 rtl/niosii_test_div_pkg.sv | 14 +
 rtl/niosii_test_div_step.sv | 19 +
 rtl/niosii_test_nios2_gen2_0_cpu_div_cell.sv | 126 ++++++++++++
 tb/tb_niosii_test_nios2_gen2_0_cpu_div_cell.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/niosii_test_div_pkg.sv
// Shared widths, state encoding and operand helper for the iterative divider.
package niosii_test_div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic             isSigned);
    return (isSigned && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/niosii_test_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module niosii_test_div_step
  import niosii_test_div_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              quot_bit_o
);

  logic [DATA_W:0] trial;

  assign trial      = {rem_i, dvd_bit_i};
  assign quot_bit_o = (trial >= {1'b0, divisor_i});
  // The difference is below the divisor whenever it is kept, so DATA_W bits suffice.
  assign rem_o      = quot_bit_o ? (trial[DATA_W-1:0] - divisor_i) : trial[DATA_W-1:0];

endmodule

// File: rtl/niosii_test_nios2_gen2_0_cpu_div_cell.sv
// Iterative 32/32 signed/unsigned divider, one quotient bit per clock.
// Optional divide-by-zero trap enabled by defining NIOSII_DIV_DZ_TRAP_EN.
module niosii_test_nios2_gen2_0_cpu_div_cell
  import niosii_test_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              E_div_start,
  input  logic              E_div_kill,
  input  logic              E_ctrl_div_signed,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quot,
  output logic [DATA_W-1:0] M_div_rem,
  output logic              M_div_dz
);

  div_state_t        state_q;
  logic [DATA_W-1:0] dvd_q, dsr_q, prem_q, quot_q, rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              negQuot_q, negRem_q, dzPend_q, dz_q, busy_q, done_q;
  logic [DATA_W-1:0] prem_d;
  logic              quotBit_d;
  logic              accept;
  logic              src2Zero;

`ifdef NIOSII_DIV_DZ_TRAP_EN
  assign src2Zero = (E_src2 == '0);
`else
  assign src2Zero = 1'b0;
`endif

  // A new operation may start from IDLE or in the done cycle itself.
  assign accept = E_div_start && !E_div_kill && ((state_q == IDLE) || (state_q == DONE));

  niosii_test_div_step u_step (
    .rem_i      (prem_q),
    .dvd_bit_i  (dvd_q[DATA_W-1]),
    .divisor_i  (dsr_q),
    .rem_o      (prem_d),
    .quot_bit_o (quotBit_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      prem_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      dzPend_q  <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= accept;
          if (accept) begin
            cnt_q <= '0;
            dz_q  <= 1'b0;
            if (src2Zero) begin
              // Trap path: FIX only forwards the raw dividend as remainder.
              state_q   <= FIX;
              dvd_q     <= '0;
              prem_q    <= E_src1;
              negQuot_q <= 1'b0;
              negRem_q  <= 1'b0;
              dzPend_q  <= 1'b1;
            end else begin
              state_q   <= CALC;
              dvd_q     <= magnitude(E_src1, E_ctrl_div_signed);
              dsr_q     <= magnitude(E_src2, E_ctrl_div_signed);
              prem_q    <= '0;
              negQuot_q <= E_ctrl_div_signed && (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
              negRem_q  <= E_ctrl_div_signed && E_src1[DATA_W-1];
              dzPend_q  <= 1'b0;
            end
          end
        end
        CALC: begin
          if (E_div_kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            prem_q <= prem_d;
            dvd_q  <= {dvd_q[DATA_W-2:0], quotBit_d};
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (E_div_kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            quot_q  <= negQuot_q ? -dvd_q : dvd_q;
            rem_q   <= negRem_q ? -prem_q : prem_q;
            dz_q    <= dzPend_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign M_div_busy = busy_q;
  assign M_div_done = done_q;
  assign M_div_quot = quot_q;
  assign M_div_rem  = rem_q;
  assign M_div_dz   = dz_q;

endmodule

// File: tb/tb_niosii_test_nios2_gen2_0_cpu_div_cell.sv
// Self-checking bench for the iterative divider: directed cases plus randomized traffic against a reference model.
module tb_niosii_test_nios2_gen2_0_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        E_div_start = 1'b0;
  logic        E_div_kill = 1'b0;
  logic        E_ctrl_div_signed = 1'b0;
  logic [31:0] E_src1 = '0;
  logic [31:0] E_src2 = '0;
  logic        M_div_busy, M_div_done, M_div_dz;
  logic [31:0] M_div_quot, M_div_rem;

  int checks = 0;
  int errors = 0;
  bit cmpEn = 1'b0;

  // Model state: cycles left in the current op, done flag and visible results.
  int          mLeft = 0;
  bit          mDone = 1'b0;
  logic [31:0] mQuot = '0, mRem = '0;
  bit          mDz = 1'b0;
  logic [31:0] pQ, pR;
  bit          pDz;
  int          pLat;

  niosii_test_nios2_gen2_0_cpu_div_cell dut (
    .clk               (clk),
    .reset             (reset),
    .E_div_start       (E_div_start),
    .E_div_kill        (E_div_kill),
    .E_ctrl_div_signed (E_ctrl_div_signed),
    .E_src1            (E_src1),
    .E_src2            (E_src2),
    .M_div_busy        (M_div_busy),
    .M_div_done        (M_div_done),
    .M_div_quot        (M_div_quot),
    .M_div_rem         (M_div_rem),
    .M_div_dz          (M_div_dz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result from plain integer division rules.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output bit dz, output int lat);
    int sa, sb;
    dz  = 1'b0;
    lat = 34;
    if (b == 0) begin
`ifdef NIOSII_DIV_DZ_TRAP_EN
      q = 32'h0; r = a; dz = 1'b1; lat = 2;
`else
      q = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF; r = a;
`endif
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mLeft = 0; mDone = 1'b0; mQuot = '0; mRem = '0; mDz = 1'b0;
    end else begin
      mDone = 1'b0;
      if (mLeft > 0) begin
        if (E_div_kill) mLeft = 0;
        else begin
          mLeft--;
          if (mLeft == 0) begin
            mDone = 1'b1; mQuot = pQ; mRem = pR; mDz = pDz;
          end
        end
      end else if (E_div_start && !E_div_kill) begin
        refDiv(E_src1, E_src2, E_ctrl_div_signed, pQ, pR, pDz, pLat);
        mLeft = pLat - 1;
        mDz   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("busy", {31'b0, M_div_busy}, {31'b0, (mLeft > 0) || mDone});
      checkOutput("done", {31'b0, M_div_done}, {31'b0, mDone});
      checkOutput("quot", M_div_quot, mQuot);
      checkOutput("rem",  M_div_rem,  mRem);
      checkOutput("dz",   {31'b0, M_div_dz}, {31'b0, mDz});
    end
  end

  // Starts one op, waits (bounded) for done and checks results against literals.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                               input logic [31:0] eq, input logic [31:0] er, input bit edz,
                               input int elat, input bit noWait);
    int lat, busyCnt;
    if (!noWait) @(negedge clk);
    E_src1 = a; E_src2 = b; E_ctrl_div_signed = sgn; E_div_kill = 1'b0; E_div_start = 1'b1;
    lat = 0; busyCnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      E_div_start = 1'b0;
      if (M_div_busy) busyCnt++;
      if (M_div_done) begin
        lat = k;
        break;
      end
    end
    checkOutput("latency", lat, elat);
    checkOutput("busy_cycles", busyCnt, elat);
    checkOutput("op_quot", M_div_quot, eq);
    checkOutput("op_rem", M_div_rem, er);
    checkOutput("op_dz", {31'b0, M_div_dz}, {31'b0, edz});
  endtask

  initial begin
    logic [31:0] tq, tr;
    bit          tdz;
    int          tlat, doneCnt;

    refDiv(32'd100, 32'd7, 1'b0, tq, tr, tdz, tlat);
    checkOutput("model_100_7_q", tq, 32'd14);
    checkOutput("model_100_7_r", tr, 32'd2);
    refDiv(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, tq, tr, tdz, tlat);
    checkOutput("model_7_m2_q", tq, 32'hFFFF_FFFD);
    checkOutput("model_7_m2_r", tr, 32'h1);

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'b0, M_div_busy}, 32'h0);
    checkOutput("rst_quot", M_div_quot, 32'h0);
    reset = 1'b0;
    cmpEn = 1'b1;

    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 1'b0);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1, 1'b0, 34, 1'b1);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 34, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 1'b0, 34, 1'b0);
`ifdef NIOSII_DIV_DZ_TRAP_EN
    applyStimulus(32'd5, 32'd0, 1'b0, 32'h0, 32'd5, 1'b1, 2, 1'b0);
`else
    applyStimulus(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b0, 34, 1'b0);
`endif

    // Ignored restart while busy, then a flush mid-calculation.
    @(negedge clk);
    E_src1 = 32'd50; E_src2 = 32'd5; E_ctrl_div_signed = 1'b0; E_div_start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      E_div_start = (k == 5);
      if (k == 5) begin E_src1 = 32'd1; E_src2 = 32'd1; end
      E_div_kill = (k == 10);
    end
    E_div_kill = 1'b0;
    @(negedge clk);
    checkOutput("kill_busy", {31'b0, M_div_busy}, 32'h0);
    doneCnt = 0;
    repeat (40) begin @(negedge clk); if (M_div_done) doneCnt++; end
    checkOutput("kill_no_done", doneCnt, 0);
    applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, 1'b0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    E_src1 = 32'h1234_5678; E_src2 = 32'h11; E_ctrl_div_signed = 1'b1; E_div_start = 1'b1;
    @(negedge clk);
    E_div_start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_busy", {31'b0, M_div_busy}, 32'h0);
    checkOutput("arst_done", {31'b0, M_div_done}, 32'h0);
    checkOutput("arst_quot", M_div_quot, 32'h0);
    checkOutput("arst_rem", M_div_rem, 32'h0);
    checkOutput("arst_dz", {31'b0, M_div_dz}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    doneCnt = 0;
    repeat (40) begin @(negedge clk); if (M_div_done) doneCnt++; end
    checkOutput("arst_no_done", doneCnt, 0);

    // Randomized traffic: starts, flushes and operands of mixed magnitude.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      E_div_start       = ($urandom_range(0, 5) == 0);
      E_div_kill        = ($urandom_range(0, 79) == 0);
      E_ctrl_div_signed = $urandom_range(0, 1);
      E_src1 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 300) : $urandom;
      case ($urandom_range(0, 7))
        0:       E_src2 = 32'h0;
        1:       E_src2 = 32'hFFFF_FFFF;
        2, 3:    E_src2 = $urandom_range(1, 20);
        default: E_src2 = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) E_src1 = 32'h8000_0000;
    end
    @(negedge clk);
    E_div_start = 1'b0; E_div_kill = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
